// File: rtl/ffram_arb_pkg.sv
// Shared types for the two-master FFRAM Wishbone arbiter.
// Holds the arbiter state encoding and the default watchdog timeout.
package ffram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1,
    DRAIN
  } arb_state_t;

  localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/ffram_arb_watchdog.sv
// Per-transaction watchdog: saturating cycle counter for the arbiter.
// Ports: clk/rst, clear (hold at 0), enable (count), expired (at limit).
module ffram_arb_watchdog
  import ffram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q;

  // Stops at LAST so a stuck slave can never wrap the count.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clear) begin
      cnt_q <= '0;
    end else if (enable && cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/ffram_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the FFRAM wrapper.
// Ports: m0_*/m1_* master buses, s_* slave bus, busy_o (not IDLE).
module ffram_wb_arbiter
  import ffram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_adr_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic        busy_o
);

  arb_state_t state_q, state_d;
  logic rr_q, rr_d;
  logic req0, req1, g1;
  logic wd_clr, wd_en, wd_exp;
  logic ack_g, err_g;

  logic        m_cyc, m_stb, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_dat, m_adr;

  assign req0 = m0_stb_i & m0_cyc_i;
  assign req1 = m1_stb_i & m1_cyc_i;
  assign g1   = (state_q == GNT1);

  assign m_cyc = g1 ? m1_cyc_i : m0_cyc_i;
  assign m_stb = g1 ? m1_stb_i : m0_stb_i;
  assign m_we  = g1 ? m1_we_i  : m0_we_i;
  assign m_sel = g1 ? m1_sel_i : m0_sel_i;
  assign m_dat = g1 ? m1_dat_i : m0_dat_i;
  assign m_adr = g1 ? m1_adr_i : m0_adr_i;

  ffram_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wd (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .clear   (wd_clr),
    .enable  (wd_en),
    .expired (wd_exp)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    wd_clr   = 1'b1;
    wd_en    = 1'b0;
    ack_g    = 1'b0;
    err_g    = 1'b0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_dat_o  = 32'h0;
    s_adr_o  = 32'h0;
    m0_dat_o = 32'h0;
    m1_dat_o = 32'h0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          req0 & ~req1: state_d = GNT0;
          ~req0 & req1: state_d = GNT1;
          req0 & req1:  state_d = rr_q ? GNT1 : GNT0;
          default:      state_d = IDLE;
        endcase
      end
      GNT0, GNT1: begin
        wd_clr  = 1'b0;
        wd_en   = ~s_ack_i;
        s_stb_o = m_stb;
        s_cyc_o = m_cyc;
        s_we_o  = m_we;
        s_sel_o = m_sel;
        s_dat_o = m_dat;
        s_adr_o = m_adr;
        if (g1) m1_dat_o = s_dat_i;
        else    m0_dat_o = s_dat_i;
        // Ack beats abort and timeout in the same cycle.
        if (s_ack_i) begin
          ack_g   = 1'b1;
          rr_d    = ~g1;
          state_d = DRAIN;
        end else if (!m_cyc) begin
          s_stb_o = 1'b0;
          s_cyc_o = 1'b0;
          rr_d    = ~g1;
          state_d = DRAIN;
        end else if (wd_exp) begin
          err_g   = 1'b1;
          rr_d    = ~g1;
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    m0_ack_o = ack_g & ~g1;
    m1_ack_o = ack_g & g1;
    m0_err_o = err_g & ~g1;
    m1_err_o = err_g & g1;
    busy_o   = (state_q != IDLE);

    // A reset cycle drops whatever is in flight on every output.
    if (wb_rst_i) begin
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_err_o = 1'b0;
      m0_dat_o = 32'h0;
      m1_dat_o = 32'h0;
      s_stb_o  = 1'b0;
      s_cyc_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = 4'h0;
      s_dat_o  = 32'h0;
      s_adr_o  = 32'h0;
      busy_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_ffram_wb_arbiter.sv
// Directed bench for ffram_wb_arbiter with a 128x32 FFRAM slave model.
// Slave acks one cycle after strobe; it can be told to never ack.
module tb_ffram_wb_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        m0_stb_i = 0, m0_cyc_i = 0, m0_we_i = 0;
  logic [3:0]  m0_sel_i = 0;
  logic [31:0] m0_dat_i = 0, m0_adr_i = 0;
  logic        m0_ack_o, m0_err_o;
  logic [31:0] m0_dat_o;
  logic        m1_stb_i = 0, m1_cyc_i = 0, m1_we_i = 0;
  logic [3:0]  m1_sel_i = 0;
  logic [31:0] m1_dat_i = 0, m1_adr_i = 0;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] m1_dat_o;
  logic        s_stb_o, s_cyc_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_o, s_adr_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic        busy_o;
  logic        no_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [128];

  always #5 wb_clk_i = ~wb_clk_i;

  ffram_wb_arbiter dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
    .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_dat_i(m0_dat_i), .m0_adr_i(m0_adr_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
    .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_dat_i(m1_dat_i), .m1_adr_i(m1_adr_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_dat_o(s_dat_o), .s_adr_o(s_adr_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .busy_o(busy_o)
  );

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s_ack_i <= 1'b0;
      s_dat_i <= 32'h0;
    end else begin
      s_ack_i <= s_cyc_o & s_stb_o & ~s_ack_i & ~no_ack;
      if (s_cyc_o && s_stb_o && !s_ack_i) begin
        s_dat_i <= mem[s_adr_o[8:2]];
        if (s_we_o) begin
          for (int b = 0; b < 4; b++)
            if (s_sel_o[b])
              mem[s_adr_o[8:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int m, input logic on,
                       input logic we, input logic [3:0] sel,
                       input logic [31:0] adr,
                       input logic [31:0] dat);
    if (m == 0) begin
      m0_stb_i = on; m0_cyc_i = on; m0_we_i = we;
      m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_stb_i = on; m1_cyc_i = on; m1_we_i = we;
      m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  // Lone-master transfer from an idle bus; ack must land at T+2.
  task automatic single(input int m, input logic we,
                        input logic [3:0] sel,
                        input logic [31:0] adr,
                        input logic [31:0] dat,
                        output logic [31:0] rd);
    int lat;
    logic oth;
    lat = 0;
    oth = 1'b0;
    rd = 32'h0;
    drive(m, 1'b1, we, sel, adr, dat);
    for (int i = 1; i <= 20; i++) begin
      if (lat == 0) begin
        @(negedge wb_clk_i);
        oth |= (m == 0) ? (m1_ack_o | m1_err_o)
                        : (m0_ack_o | m0_err_o);
        if ((m == 0) ? m0_ack_o : m1_ack_o) begin
          lat = i;
          rd = (m == 0) ? m0_dat_o : m1_dat_o;
          drive(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
      end
    end
    check("ack_latency", lat, 2);
    @(negedge wb_clk_i);
    check("drain_busy", {busy_o, s_cyc_o}, 32'h2);
    @(negedge wb_clk_i);
    check("idle_busy", busy_o, 0);
    check("other_quiet", oth, 0);
  endtask

  // Both masters request in the same cycle.
  task automatic contend(input int first);
    int a0, a1;
    logic k0, k1;
    a0 = 0;
    a1 = 0;
    drive(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h11111111);
    drive(1, 1'b1, 1'b1, 4'hF, 32'h24, 32'h22222222);
    for (int i = 1; i <= 12; i++) begin
      @(negedge wb_clk_i);
      k0 = m0_ack_o;
      k1 = m1_ack_o;
      if (i == 1)
        check("ungranted_dat",
              first == 0 ? m1_dat_o : m0_dat_o, 0);
      if (k0 && a0 == 0) begin
        a0 = i;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      if (k1 && a1 == 0) begin
        a1 = i;
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
    end
    check("cont_m0_ack", a0, first == 0 ? 2 : 6);
    check("cont_m1_ack", a1, first == 0 ? 6 : 2);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int ec, ne, a1, a0;
    logic [31:0] r1;

    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #1;
    check("rst_flags",
          {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o,
           s_stb_o, s_cyc_o, s_we_o, busy_o}, 0);
    check("rst_sel", s_sel_o, 0);
    check("rst_sdat", s_dat_o, 0);
    check("rst_sadr", s_adr_o, 0);
    check("rst_mdat", m0_dat_o | m1_dat_o, 0);
    check("rst_rr", dut.rr_q, 0);

    single(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd);
    single(1, 1'b0, 4'hF, 32'h10, 32'h0, rd);
    check("m1_readback", rd, 32'hDEADBEEF);

    contend(0);
    single(0, 1'b0, 4'hF, 32'h20, 32'h0, rd);
    check("cont_wr_m0", rd, 32'h11111111);
    contend(1);

    single(1, 1'b1, 4'b0100, 32'h10, 32'h00AA0000, rd);
    single(0, 1'b0, 4'hF, 32'h10, 32'h0, rd);
    check("byte_lane", rd, 32'hDEAABEEF);

    // Watchdog: slave goes silent while M0 owns the bus.
    no_ack = 1'b1;
    ec = 0; ne = 0; a1 = 0; a0 = 0; r1 = 0;
    drive(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    for (int i = 1; i <= 30; i++) begin
      @(negedge wb_clk_i);
      if (i == 1)
        drive(1, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
      if (ec != 0 && i == ec + 1)
        no_ack = 1'b0;
      if (m0_ack_o) a0++;
      if (m0_err_o) begin
        ne++;
        if (ec == 0) begin
          ec = i;
          drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
      end
      if (m1_ack_o && a1 == 0) begin
        a1 = i;
        r1 = m1_dat_o;
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
    end
    no_ack = 1'b0;
    check("wd_err_cycle", ec, 16);
    check("wd_err_pulses", ne, 1);
    check("wd_no_m0_ack", a0, 0);
    check("wd_m1_ack", a1, 20);
    check("wd_m1_dat", r1, 32'h22222222);

    // Abort: M1 drops cyc while granted.
    drive(1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge wb_clk_i);
    check("abort_gnt", {busy_o, s_cyc_o}, 32'h3);
    m1_cyc_i = 1'b0;
    #1;
    check("abort_scyc", {s_cyc_o, s_stb_o, m1_ack_o}, 0);
    @(negedge wb_clk_i);
    check("abort_drain", {busy_o, m1_ack_o, s_cyc_o}, 32'h4);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge wb_clk_i);
    check("abort_idle", {busy_o, m1_ack_o}, 0);

    // Reset while M0 is granted.
    drive(0, 1'b1, 1'b1, 4'hF, 32'h30, 32'h55);
    @(negedge wb_clk_i);
    check("rst_gnt0", busy_o, 1);
    wb_rst_i = 1'b1;
    #1;
    check("rst_mid_out",
          {m0_ack_o, m0_err_o, busy_o, s_cyc_o, s_stb_o}, 0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("rst_idle", {busy_o, m0_ack_o, m0_err_o}, 0);
    @(negedge wb_clk_i);
    check("rst_quiet", {busy_o, m0_ack_o, m0_err_o}, 0);
    check("rst_rr_mid", dut.rr_q, 0);
    contend(0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
